// File: rtl/grf_pkg.sv
// Shared constants and helpers for the general register file with scoreboard.
package grf_pkg;

  localparam int GRF_DW    = 32;
  localparam int GRF_NREG  = 32;
  localparam int GRF_NREAD = 2;

  function automatic int aw_of(input int nreg);
    return $clog2(nreg);
  endfunction

endpackage

// File: rtl/grf_sb_if.sv
// Register-file bus: read ports, writeback, issue and the sticky error flag.
// Issue and writeback are valid-only: the file accepts them on every edge,
// so there is no ready; a request is taken at the rising edge where valid is high.
interface grf_sb_if
  import grf_pkg::*;
#(
  parameter int DW    = GRF_DW,
  parameter int NREG  = GRF_NREG,
  parameter int NREAD = GRF_NREAD,
  parameter int AW    = aw_of(NREG)
) ();

  logic [NREAD*AW-1:0] ra;
  logic [NREAD*DW-1:0] rd;
  logic [NREAD-1:0]    rd_busy;
  logic                we;
  logic [AW-1:0]       wa;
  logic [DW-1:0]       wd;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic                err;

  modport master (
    output ra, we, wa, wd, iss_valid, iss_addr,
    input  rd, rd_busy, err
  );

  modport slave (
    input  ra, we, wa, wd, iss_valid, iss_addr,
    output rd, rd_busy, err
  );

endinterface

// File: rtl/grf_scoreboard.sv
// Pending-write scoreboard: issue sets, writeback clears, issue wins on a tie.
// err latches a writeback to a register nobody was producing.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int NREG = GRF_NREG,
  parameter int AW   = aw_of(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_addr,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  output logic [NREG-1:0] pend,
  output logic            err
);

  logic [NREG-1:0] pend_nxt;
  logic            err_set;
  logic            wb_act;
  logic            iss_act;

  assign wb_act  = we && (wa != '0);
  assign iss_act = iss_valid && (iss_addr != '0);

  // Clear first, then set, so a same-cycle issue to the written register keeps it pending.
  always_comb begin
    pend_nxt = pend;
    if (wb_act)  pend_nxt[wa]       = 1'b0;
    if (iss_act) pend_nxt[iss_addr] = 1'b1;
  end

  assign err_set = wb_act && !pend[wa] && !(iss_act && (iss_addr == wa));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
      err  <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: rtl/grf_sb.sv
// General register file with combinational read ports and a pending-write scoreboard.
// Define GRF_BYPASS_EN to forward same-cycle writeback data onto matching read ports.
module grf_sb
  import grf_pkg::*;
#(
  parameter int DW    = GRF_DW,
  parameter int NREG  = GRF_NREG,
  parameter int NREAD = GRF_NREAD,
  parameter int AW    = aw_of(NREG)
) (
  input logic   clk,
  input logic   reset,
  grf_sb_if.slave bus
);

  logic [DW-1:0]       regs [NREG];
  logic [NREG-1:0]     pend;
  logic [NREAD*DW-1:0] rd_v;
  logic [NREAD-1:0]    busy_v;

  grf_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (bus.iss_valid),
    .iss_addr  (bus.iss_addr),
    .we        (bus.we),
    .wa        (bus.wa),
    .pend      (pend),
    .err       (bus.err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.we && (bus.wa != '0)) begin
      regs[bus.wa] <= bus.wd;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    logic          zero;

    assign a = bus.ra[k*AW +: AW];
`ifdef GRF_BYPASS_EN
    assign hit = bus.we && (bus.wa != '0) && (bus.wa == a);
`else
    assign hit = 1'b0;
`endif
    // Reset forces zero even if a write is presented, so bypass cannot leak through.
    assign zero = reset || (a == '0);

    assign rd_v[k*DW +: DW] = zero ? '0 : (hit ? bus.wd : regs[a]);
    assign busy_v[k]        = (zero || hit) ? 1'b0 : pend[a];
  end

  assign bus.rd      = rd_v;
  assign bus.rd_busy = busy_v;

endmodule

// File: tb/tb_grf_sb.sv
// Directed bench for grf_sb: a per-cycle vector table plus reset and sticky-error sequences.
module tb_grf_sb;

`ifdef GRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  grf_sb_if #(.DW(32), .NREG(32), .NREAD(2)) bus ();

  grf_sb #(.DW(32), .NREG(32), .NREAD(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ra0, ra1;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ia;
    logic [31:0] e_rd0, e_rd1;
    logic        e_b0, e_b1, e_err;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(logic [4:0] ra0, logic [4:0] ra1, logic we, logic [4:0] wa,
                              logic [31:0] wd, logic iv, logic [4:0] ia,
                              logic [31:0] e_rd0, logic [31:0] e_rd1,
                              logic e_b0, logic e_b1, logic e_err);
    vec_t v;
    v.ra0 = ra0; v.ra1 = ra1; v.we = we; v.wa = wa; v.wd = wd; v.iv = iv; v.ia = ia;
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_b0 = e_b0; v.e_b1 = e_b1; v.e_err = e_err;
    return v;
  endfunction

  task automatic drive(logic [4:0] ra0, logic [4:0] ra1, logic we, logic [4:0] wa,
                       logic [31:0] wd, logic iv, logic [4:0] ia);
    bus.ra        = {ra1, ra0};
    bus.we        = we;
    bus.wa        = wa;
    bus.wd        = wd;
    bus.iss_valid = iv;
    bus.iss_addr  = ia;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [31:0] rd0, logic [31:0] rd1,
                         logic b0, logic b1, logic e);
    chk({tag, " rd0"},   bus.rd[31:0],     rd0);
    chk({tag, " rd1"},   bus.rd[63:32],    rd1);
    chk({tag, " busy0"}, 32'(bus.rd_busy[0]), 32'(b0));
    chk({tag, " busy1"}, 32'(bus.rd_busy[1]), 32'(b1));
    chk({tag, " err"},   32'(bus.err),     32'(e));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);

    //            ra0 ra1 we wa wd            iv ia  rd0                          rd1                          b0        b1        err
    tab.push_back(mk(0, 3, 0, 0, 32'h0,        1, 3,  32'h0,                       32'h0,                       0,        0,        0));
    tab.push_back(mk(0, 3, 0, 0, 32'h0,        0, 0,  32'h0,                       32'h0,                       0,        1,        0));
    tab.push_back(mk(0, 3, 1, 3, 32'h12345678, 0, 0,  32'h0,                       BYP ? 32'h12345678 : 32'h0,  0,        !BYP,     0));
    tab.push_back(mk(0, 3, 0, 0, 32'h0,        0, 0,  32'h0,                       32'h12345678,                0,        0,        0));
    tab.push_back(mk(0, 0, 0, 0, 32'h0,        1, 7,  32'h0,                       32'h0,                       0,        0,        0));
    tab.push_back(mk(7, 0, 1, 7, 32'h11,       1, 7,  BYP ? 32'h11 : 32'h0,        32'h0,                       !BYP,     0,        0));
    tab.push_back(mk(7, 7, 1, 7, 32'hA5A5A5A5, 0, 0,  BYP ? 32'hA5A5A5A5 : 32'h11, BYP ? 32'hA5A5A5A5 : 32'h11, !BYP,     !BYP,     0));
    tab.push_back(mk(7, 7, 0, 0, 32'h0,        0, 0,  32'hA5A5A5A5,                32'hA5A5A5A5,                0,        0,        0));
    tab.push_back(mk(0, 0, 0, 0, 32'h0,        1, 0,  32'h0,                       32'h0,                       0,        0,        0));
    tab.push_back(mk(0, 0, 1, 0, 32'hFFFFFFFF, 0, 0,  32'h0,                       32'h0,                       0,        0,        0));
    tab.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0,  32'h0,                       32'h0,                       0,        0,        0));
    tab.push_back(mk(0, 0, 0, 0, 32'h0,        1, 9,  32'h0,                       32'h0,                       0,        0,        0));
    tab.push_back(mk(9, 0, 1, 9, 32'h42,       1, 9,  BYP ? 32'h42 : 32'h0,        32'h0,                       !BYP,     0,        0));
    tab.push_back(mk(9, 0, 0, 0, 32'h0,        0, 0,  32'h42,                      32'h0,                       1,        0,        0));
    tab.push_back(mk(0, 9, 1, 9, 32'h55,       0, 0,  32'h0,                       BYP ? 32'h55 : 32'h42,       0,        !BYP,     0));
    tab.push_back(mk(9, 3, 0, 0, 32'h0,        0, 0,  32'h55,                      32'h12345678,                0,        0,        0));
    tab.push_back(mk(4, 0, 1, 4, 32'h1,        0, 0,  BYP ? 32'h1 : 32'h0,         32'h0,                       0,        0,        0));
    tab.push_back(mk(4, 0, 0, 0, 32'h0,        0, 0,  32'h1,                       32'h0,                       0,        0,        1));

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (tab[i]) begin
      if (i != 0) @(negedge clk);
      drive(tab[i].ra0, tab[i].ra1, tab[i].we, tab[i].wa, tab[i].wd, tab[i].iv, tab[i].ia);
      #2;
      chk_all($sformatf("vec%0d", i), tab[i].e_rd0, tab[i].e_rd1, tab[i].e_b0, tab[i].e_b1, tab[i].e_err);
    end

    // err is sticky across clean cycles
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(4, 0, 0, 0, 0, 0, 0);
      #2;
      chk($sformatf("err_hold%0d", c), 32'(bus.err), 32'd1);
    end

    // Reset mid-cycle clears storage, pend and err without an edge
    @(negedge clk);
    drive(0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    @(negedge clk);
    drive(5, 6, 0, 0, 0, 1, 6);
    #2;
    chk("r5_before_reset", bus.rd[31:0], 32'hDEADBEEF);
    @(negedge clk);
    drive(5, 6, 1, 5, 32'h1, 0, 0);
    #2;
    chk("r6_busy_before_reset", 32'(bus.rd_busy[1]), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk_all("in_reset", 32'h0, 32'h0, 0, 0, 0);
    @(negedge clk);
    drive(5, 6, 1, 5, 32'h2, 1, 6);
    #2;
    chk_all("reset_held", 32'h0, 32'h0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(5, 6, 0, 0, 0, 0, 0);
    #2;
    chk_all("after_reset", 32'h0, 32'h0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 1, 5, 32'h77, 0, 0);
    @(negedge clk);
    drive(5, 0, 0, 0, 0, 0, 0);
    #2;
    chk_all("post_reset_write", 32'h77, 32'h0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
